// File: rtl/regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile : 32 x WIDTH integer register file, 2 async read ports, 1 write port
// Revision: 1.0
// ----------------------------------------------------------------------------
module regfile #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write,
  input  logic [4:0]       wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [4:0]       rd_reg1,
  input  logic [4:0]       rd_reg2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2
);

  localparam int c_NUM_STORED = 31;

  logic [WIDTH-1:0] regs_q [0:c_NUM_STORED-1];
  logic [WIDTH-1:0] regs_d [0:c_NUM_STORED-1];
  logic [c_NUM_STORED-1:0] w_en;
  logic [WIDTH-1:0] w_bank [0:31];

  logic [WIDTH-1:0] w_lo1, w_hi1, w_lo2, w_hi2;

  // Index 31 has no decoder output, so writes to it vanish.
  generate
    for (genvar i = 0; i < c_NUM_STORED; i++) begin : g_dec
      assign w_en[i] = reg_write & (wr_reg == 5'(i));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < c_NUM_STORED; i++) begin
      regs_d[i] = w_en[i] ? wr_data : regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_NUM_STORED; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_NUM_STORED; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Constant zero in slot 31 keeps it immune to any write-control value.
  generate
    for (genvar i = 0; i < 32; i++) begin : g_bank
      if (i == 31) begin : g_zero
        assign w_bank[i] = '0;
      end else begin : g_reg
        assign w_bank[i] = regs_q[i];
      end
    end
  endgenerate

  // 16:1 stage on select[3:0] for each half, then 2:1 on select[4].
  always_comb begin
    w_lo1    = w_bank[{1'b0, rd_reg1[3:0]}];
    w_hi1    = w_bank[{1'b1, rd_reg1[3:0]}];
    w_lo2    = w_bank[{1'b0, rd_reg2[3:0]}];
    w_hi2    = w_bank[{1'b1, rd_reg2[3:0]}];
    rd_data1 = rd_reg1[4] ? w_hi1 : w_lo1;
    rd_data2 = rd_reg2[4] ? w_hi2 : w_lo2;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`timescale 1ns/10ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile : directed self-checking bench for regfile
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_regfile;

  localparam int WIDTH = 64;
  localparam logic [WIDTH-1:0] c_STEP = 64'h0101_0101_0101_0101;

  logic             clk;
  logic             reset;
  logic             reg_write;
  logic [4:0]       wr_reg;
  logic [WIDTH-1:0] wr_data;
  logic [4:0]       rd_reg1;
  logic [4:0]       rd_reg2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;

  int total = 0;
  int bad   = 0;

  regfile #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .reg_write(reg_write),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .rd_reg1  (rd_reg1),
    .rd_reg2  (rd_reg2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [4:0] idx, input logic [WIDTH-1:0] data);
    @(negedge clk);
    reg_write = 1'b1;
    wr_reg    = idx;
    wr_data   = data;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic test_reset();
    // Reset state out of power-up
    for (int i = 0; i < 32; i++) begin
      rd_reg1 = 5'(i);
      rd_reg2 = 5'(31 - i);
      #1;
      total++;
      if (rd_data1 !== '0 || rd_data2 !== '0) begin
        bad++;
        $display("FAIL reset_init idx=%0d: got %h/%h required 0/0", i, rd_data1, rd_data2);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    do_write(5'd2, 64'hCAFE_F00D_1234_5678);
    do_write(5'd30, 64'h8000_0000_0000_0001);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_reg1 = 5'(i);
      rd_reg2 = 5'(31 - i);
      #1;
      total++;
      if (rd_data1 !== '0 || rd_data2 !== '0) begin
        bad++;
        $display("FAIL reset_sweep idx=%0d: got %h/%h required 0/0", i, rd_data1, rd_data2);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_sweep();
    for (int i = 0; i < 31; i++) begin
      do_write(5'(i), 64'(i) * c_STEP);
    end
    for (int i = 0; i < 31; i++) begin
      rd_reg1 = 5'(i);
      rd_reg2 = 5'(30 - i);
      #5;
      total++;
      if (rd_data1 !== 64'(i) * c_STEP || rd_data2 !== 64'(30 - i) * c_STEP) begin
        bad++;
        $display("FAIL write_sweep idx=%0d: got %h/%h required %h/%h", i, rd_data1, rd_data2,
                 64'(i) * c_STEP, 64'(30 - i) * c_STEP);
      end
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_reg1 = 5'd31;
    rd_reg2 = 5'd31;
    #5;
    total++;
    if (rd_data1 !== '0 || rd_data2 !== '0) begin
      bad++;
      $display("FAIL zero_reg: got %h/%h required 0/0", rd_data1, rd_data2);
    end
    for (int i = 0; i < 31; i++) begin
      rd_reg1 = 5'(i);
      rd_reg2 = 5'(i);
      #5;
      total++;
      if (rd_data1 !== 64'(i) * c_STEP || rd_data2 !== 64'(i) * c_STEP) begin
        bad++;
        $display("FAIL zero_reg_others idx=%0d: got %h/%h required %h", i, rd_data1, rd_data2,
                 64'(i) * c_STEP);
      end
    end
  endtask

  task automatic test_write_disabled();
    @(negedge clk);
    reg_write = 1'b0;
    wr_reg    = 5'd5;
    wr_data   = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk);
    @(posedge clk);
    #1;
    rd_reg1 = 5'd5;
    rd_reg2 = 5'd5;
    #5;
    total++;
    if (rd_data1 !== 64'h0505_0505_0505_0505 || rd_data2 !== 64'h0505_0505_0505_0505) begin
      bad++;
      $display("FAIL write_disabled: got %h/%h required %h", rd_data1, rd_data2,
               64'h0505_0505_0505_0505);
    end
  endtask

  task automatic test_read_during_write();
    do_write(5'd7, 64'h1234);
    @(negedge clk);
    rd_reg1   = 5'd7;
    rd_reg2   = 5'd7;
    reg_write = 1'b1;
    wr_reg    = 5'd7;
    wr_data   = 64'h5678;
    #1;
    total++;
    if (rd_data1 !== 64'h1234 || rd_data2 !== 64'h1234) begin
      bad++;
      $display("FAIL rdw_before: got %h/%h required 1234", rd_data1, rd_data2);
    end
    @(posedge clk);
    #1;
    total++;
    if (rd_data1 !== 64'h5678 || rd_data2 !== 64'h5678) begin
      bad++;
      $display("FAIL rdw_after: got %h/%h required 5678", rd_data1, rd_data2);
    end
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    do_write(5'd3, 64'hA5A5);
    rd_reg1 = 5'd3;
    rd_reg2 = 5'd3;
    #1;
    total++;
    if (rd_data1 !== 64'hA5A5) begin
      bad++;
      $display("FAIL mid_reset_load: got %h required a5a5", rd_data1);
    end
    @(negedge clk);
    reg_write = 1'b1;
    wr_reg    = 5'd3;
    wr_data   = 64'h1;
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (rd_data1 !== '0 || rd_data2 !== '0) begin
      bad++;
      $display("FAIL mid_reset_async: got %h/%h required 0/0", rd_data1, rd_data2);
    end
    @(posedge clk);
    #1;
    total++;
    if (rd_data1 !== '0) begin
      bad++;
      $display("FAIL mid_reset_blocked: got %h required 0", rd_data1);
    end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (rd_data1 !== '0) begin
      bad++;
      $display("FAIL mid_reset_pending: got %h required 0", rd_data1);
    end
    @(posedge clk);
    #1;
    total++;
    if (rd_data1 !== 64'h1 || rd_data2 !== 64'h1) begin
      bad++;
      $display("FAIL mid_reset_landed: got %h/%h required 1", rd_data1, rd_data2);
    end
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    reg_write = 1'b0;
    wr_reg    = '0;
    wr_data   = '0;
    rd_reg1   = '0;
    rd_reg2   = '0;
    @(posedge clk);
    @(posedge clk);
    test_reset();
    test_write_sweep();
    test_zero_reg();
    test_write_disabled();
    test_read_during_write();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
